burst_dram_model: RTL and testbench

- Parametrised behavioural DRAM model behind the data cache controller; successor to the single-word zero-latency dummy DRAM.
- Adds configurable read latency, cache-line bursts and a proper request/accept handshake.
- Adds separate read-valid and write-ready beat handshakes, busy indication and write-completion pulse.
- Bench-level model (not synthesised for silicon); must simulate cycle-accurately so cache miss/refill timing can be verified.

---
 rtl/dram_pkg.sv | 25 ++
 rtl/dram_array.sv | 33 +++
 rtl/burst_dram_model.sv | 187 ++++++++++++++++++
 tb/tb_burst_dram_model.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the burst DRAM model: FSM state encoding,
// LSU operation codes and a width helper for the beat index.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_RESP
  } dram_state_t;

  localparam logic LSU_LW = 1'b0;
  localparam logic LSU_SW = 1'b1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dram_array.sv
// Word storage for the burst DRAM model: one synchronous write port, one
// registered read port whose output holds until the next read; rst clears all.
module dram_array
  import dram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/burst_dram_model.sv
// Burst DRAM model with read latency and line bursts. Define DRAM_STATS_EN to
// build the completed-burst counters rd_count/wr_count; otherwise they read 0.
module burst_dram_model
  import dram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = 4,
  parameter int READ_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              lsu_operator,
  input  logic [31:0]       mem_address,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] dram_data_out,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] write_data_int,
  output logic              wr_ready,
  output logic              wr_done,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output dram_state_t       fsm_state
);

  localparam int BEAT_W = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  // Handshakes: a request is accepted on an edge where mem_req && mem_ready;
  // read beats are pushed with rd_valid (no backpressure); write beats move on
  // edges where wr_valid && wr_ready; wr_done pulses once after the last beat.
  dram_state_t       state;
  logic [BEAT_W-1:0] beat;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] base;
  logic              rd_valid_q, wr_ready_q, wr_done_q;
  logic              accept;
  logic [ADDR_W-1:0] req_base;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              unused_addr;

  assign accept      = mem_req && (state == IDLE);
  assign req_base    = mem_address[ADDR_W-1:0] & LINE_MASK;
  assign unused_addr = ^mem_address[31:ADDR_W];

  assign mem_ready = accept;
  assign mem_busy  = (state != IDLE);
  assign rd_valid  = rd_valid_q;
  assign wr_ready  = wr_ready_q;
  assign wr_done   = wr_done_q;
  assign fsm_state = state;

  // The read for a beat is issued one cycle early so the registered array
  // output lines up with rd_valid.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = base;
    case (state)
      IDLE: begin
        if (accept && lsu_operator == LSU_LW && READ_LAT == 1) begin
          rd_en   = 1'b1;
          rd_addr = req_base;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 4'd1) rd_en = 1'b1;
      end
      RD_BURST: begin
        if (beat != LAST_BEAT) begin
          rd_en   = 1'b1;
          rd_addr = base + ADDR_W'(beat) + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign wr_en   = (state == WR_BURST) && wr_valid;
  assign wr_addr = base + ADDR_W'(beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      lat_cnt    <= '0;
      base       <= '0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base <= req_base;
            beat <= '0;
            if (lsu_operator == LSU_SW) begin
              state      <= WR_BURST;
              wr_ready_q <= 1'b1;
            end else if (READ_LAT == 1) begin
              state      <= RD_BURST;
              rd_valid_q <= 1'b1;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 4'd1) begin
            state      <= RD_BURST;
            rd_valid_q <= 1'b1;
            lat_cnt    <= '0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_BURST: begin
          if (beat == LAST_BEAT) begin
            state      <= IDLE;
            rd_valid_q <= 1'b0;
            beat       <= '0;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        WR_BURST: begin
          if (wr_valid) begin
            if (beat == LAST_BEAT) begin
              state      <= WR_RESP;
              wr_ready_q <= 1'b0;
              wr_done_q  <= 1'b1;
              beat       <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        WR_RESP: begin
          state     <= IDLE;
          wr_done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state == RD_BURST && beat == LAST_BEAT) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state == WR_RESP) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  dram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (write_data_int),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (dram_data_out)
  );

endmodule

// File: tb/tb_burst_dram_model.sv
// Bench for burst_dram_model: a timing/memory model derived from accept times
// and burst arithmetic, checked every cycle, plus literal line-level checks.
module tb_burst_dram_model;
  import dram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BL = 4;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        lsu_operator;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic        mem_busy;
  logic        rd_valid;
  logic [DW-1:0] dram_data_out;
  logic        wr_valid;
  logic [DW-1:0] write_data_int;
  logic        wr_ready;
  logic        wr_done;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  dram_state_t fsm_state;

  burst_dram_model #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .lsu_operator(lsu_operator),
    .mem_address(mem_address), .mem_ready(mem_ready), .mem_busy(mem_busy),
    .rd_valid(rd_valid), .dram_data_out(dram_data_out), .wr_valid(wr_valid),
    .write_data_int(write_data_int), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_count(rd_count), .wr_count(wr_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 read line, 2 write line, 3 write response
  int          cyc = 0;
  int          mode = 0;
  int          acc = 0;
  int          base_m = 0;
  int          wbeat = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  bit          seen_rst = 0;
  logic [DW-1:0] mm [0:(1<<AW)-1];
  logic [DW-1:0] last_data;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
      mode = 0;
      last_data = '0;
      exp_rd = 0;
      exp_wr = 0;
      seen_rst = 1;
    end else begin
      case (mode)
        0: if (mem_req) begin
          acc = cyc;
          base_m = int'(mem_address[AW-1:0]) & ~(BL - 1);
          mode = lsu_operator ? 2 : 1;
          wbeat = 0;
        end
        1: if (cyc == acc + RL + BL - 1) begin
          mode = 0;
          exp_rd++;
        end
        2: if (wr_valid) begin
          mm[base_m + wbeat] = write_data_int;
          wbeat++;
          if (wbeat == BL) mode = 3;
        end
        default: begin
          mode = 0;
          exp_wr++;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [DW-1:0] cap_q [$];
  int first_rv_cyc = 0;
  int wd_cyc = 0;

  always @(posedge clk) begin
    bit exp_valid;
    #3;
    if (seen_rst) begin
      exp_valid = (mode == 1) && (cyc >= acc + RL - 1);
      if (exp_valid) last_data = mm[base_m + cyc - (acc + RL - 1)];
      check("mem_ready", mem_ready, mem_req && (mode == 0));
      check("mem_busy", mem_busy, mode != 0);
      check("rd_valid", rd_valid, exp_valid);
      check("dram_data_out", dram_data_out, last_data);
      check("wr_ready", wr_ready, mode == 2);
      check("wr_done", wr_done, mode == 3);
      check("state_idle", fsm_state == IDLE, mode == 0);
`ifdef DRAM_STATS_EN
      check("rd_count", rd_count, exp_rd);
      check("wr_count", wr_count, exp_wr);
`else
      check("rd_count", rd_count, 0);
      check("wr_count", wr_count, 0);
`endif
      if (rd_valid) begin
        if (cap_q.size() == 0) first_rv_cyc = cyc;
        cap_q.push_back(dram_data_out);
      end
      if (wr_done) wd_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic wait_ready(output int t);
    int n;
    n = 0;
    #1;
    while (!mem_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!mem_ready) check("accept_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic do_req(input logic op, input logic [31:0] addr);
    int t;
    @(negedge clk);
    mem_req = 1'b1;
    lsu_operator = op;
    mem_address = addr;
    wait_ready(t);
    @(negedge clk);
    mem_req = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic read_line(input logic [31:0] addr);
    cap_q.delete();
    do_req(LSU_LW, addr);
    repeat (RL + BL + 1) @(negedge clk);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                            input int stall_at, input int stall_len);
    logic [DW-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    // junk beat alongside the request must be ignored
    wr_valid = 1'b1;
    write_data_int = 32'hDEAD_BEEF;
    do_req(LSU_SW, addr);
    for (int i = 0; i < BL; i++) begin
      if (i == stall_at) begin
        wr_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      wr_valid = 1'b1;
      write_data_int = d[i];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_line(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, "_beats"}, cap_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_q.size()) check(name, cap_q[i], e[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t1, t2;
    rst = 1'b1;
    mem_req = 1'b0;
    lsu_operator = 1'b0;
    mem_address = '0;
    wr_valid = 1'b0;
    write_data_int = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", mem_busy, 0);
    check("reset_data", dram_data_out, 0);
    rst = 1'b0;

    // LW 0x10 from cleared memory: first beat 4 cycles after the ready cycle
    read_line(32'h10);
    check("rd_first_latency", first_rv_cyc - acc_cyc, 3);
    check_line("lw_0x10", 0, 0, 0, 0);

    // SW 0x22 hits line 0x20..0x23
    write_line(32'h22, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4, 0);
    check("wr_done_latency", wd_cyc - acc_cyc, 4);
    read_line(32'h21);
    check_line("lw_0x21", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

`ifdef DRAM_STATS_EN
    check("stats_rd", rd_count, 2);
    check("stats_wr", wr_count, 1);
`else
    check("stats_rd", rd_count, 0);
    check("stats_wr", wr_count, 0);
`endif

    // write with a 3-cycle wr_valid gap between beats 1 and 2
    write_line(32'h30, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 2, 3);
    check("wr_done_stall", wd_cyc - acc_cyc, 7);
    read_line(32'h33);
    check_line("lw_0x33", 32'hB0, 32'hB1, 32'hB2, 32'hB3);

    // mem_req held through a read burst
    @(negedge clk);
    mem_req = 1'b1;
    lsu_operator = LSU_LW;
    mem_address = 32'h10;
    wait_ready(t1);
    @(negedge clk);
    wait_ready(t2);
    @(negedge clk);
    mem_req = 1'b0;
    check("held_req_gap", t2 - t1, 8);
    repeat (RL + BL + 2) @(negedge clk);

    // reset on the second beat of a read of line 0x20
    cap_q.delete();
    do_req(LSU_LW, 32'h20);
    repeat (RL) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_beats_before", cap_q.size(), 2);
    if (cap_q.size() >= 2) check("rst_beat1", cap_q[1], 32'hA1);
    check("rst_no_valid", rd_valid, 0);
    read_line(32'h20);
    check_line("lw_after_rst", 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
